instr_encoder: RTL

Streaming RV32I instruction encoder, the inverse of the opcode/field decode path. It accepts decoded instruction fields (opcode, registers, funct3/funct7, 32-bit immediate) over a valid/ready handshake. It range-checks the immediate, packs the fields into a 32-bit instruction word per the opcode's format, and emits the word with a sequential instruction-memory word address. Used by the program loader and the self-test generator to fill instruction memory.

---
 rtl/instr_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: range-checks the immediate, packs fields by opcode format,
// and emits each legal word with a sequential instruction-memory address.
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              full,
   output logic              err,
   output logic [7:0]        err_count
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [ADDR_W-1:0] r_ptr;
   logic              r_full;
   logic              r_err;
   logic [7:0]        r_err_count;
   logic              r_out_valid;
   logic [31:0]       r_instr;
   logic [ADDR_W-1:0] r_out_addr;

   logic              w_accept;
   logic              w_transfer;
   logic              w_legal;
   logic [31:0]       w_word;
   logic [ADDR_W-1:0] w_ptr_inc;
   logic              w_imm12_ok;
   logic              w_imm13_ok;
   logic              w_imm21_ok;
   logic              w_shamt_ok;
   logic              w_is_shift;

   assign in_ready   = !clear && !r_full && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_transfer = r_out_valid && out_ready;
   assign w_ptr_inc  = r_ptr + 1'b1;

   // Signed range checks: upper bits must all equal the sign bit of the field width.
   assign w_imm12_ok = (imm[31:11] == '0) || (&imm[31:11]);
   assign w_imm13_ok = (imm[31:12] == '0) || (&imm[31:12]);
   assign w_imm21_ok = (imm[31:20] == '0) || (&imm[31:20]);
   assign w_shamt_ok = (imm[31:5] == '0);
   assign w_is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      w_legal = 1'b0;
      w_word  = '0;
      case (opcode)
         OP_R: begin
            w_legal = 1'b1;
            w_word  = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         OP_IMM: begin
            if (w_is_shift) begin
               w_legal = w_shamt_ok;
               w_word  = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            end else begin
               w_legal = w_imm12_ok;
               w_word  = {imm[11:0], rs1, funct3, rd, opcode};
            end
         end
         OP_LOAD, OP_JALR: begin
            w_legal = w_imm12_ok;
            w_word  = {imm[11:0], rs1, funct3, rd, opcode};
         end
         OP_STORE: begin
            w_legal = w_imm12_ok;
            w_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         end
         OP_BRANCH: begin
            w_legal = w_imm13_ok && !imm[0];
            w_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         end
         OP_LUI, OP_AUIPC: begin
            w_legal = (imm[11:0] == '0);
            w_word  = {imm[31:12], rd, opcode};
         end
         OP_JAL: begin
            w_legal = w_imm21_ok && !imm[0];
            w_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         end
         default: begin
            w_legal = 1'b0;
            w_word  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= BASE;
         r_full      <= 1'b0;
         r_err       <= 1'b0;
         r_err_count <= '0;
         r_out_valid <= 1'b0;
         r_instr     <= '0;
         r_out_addr  <= BASE;
      end else if (clear) begin
         r_ptr       <= BASE;
         r_full      <= 1'b0;
         r_err       <= 1'b0;
         r_err_count <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept && w_legal) begin
            r_out_valid <= 1'b1;
            r_instr     <= w_word;
            r_out_addr  <= r_ptr;
            r_ptr       <= w_ptr_inc;
            if (w_ptr_inc == BASE) begin
               r_full <= 1'b1;
            end
         end else if (w_transfer) begin
            r_out_valid <= 1'b0;
         end
         // Rejected bundles are consumed but only bump the error state.
         if (w_accept && !w_legal) begin
            r_err <= 1'b1;
            if (r_err_count != 8'hFF) begin
               r_err_count <= r_err_count + 8'd1;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign instr     = r_instr;
   assign out_addr  = r_out_addr;
   assign full      = r_full;
   assign err       = r_err;
   assign err_count = r_err_count;

endmodule
